alu_uart_requester: RTL and testbench
=====================================

# alu_uart_requester

Host-side initiator for the UART ALU link. It accepts one operand/opcode request and drives the local UART transmitter to send byte A, then byte B, then the opcode byte. It then waits for the single result byte from the local UART receiver and returns it on a valid/ready response port. It is the counterpart of the ALU-side interface that collects A/B/opcode and sends back the result, and it is used both in the system bench and as a loopback master on the board.

## Interface
- DATA_SIZE, 8, width of operand, result and UART bytes
- OPCODE_SIZE, 6, opcode width; sent zero-extended to DATA_SIZE
- TIMEOUT_CYCLES, 1000000, maximum cycles in WAIT_RX before abort; 0 disables the timeout
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

- i_clk  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE
- i_req_a  in  DATA_SIZE  operand A
- i_req_b  in  DATA_SIZE  operand B
- i_req_opcode  in  OPCODE_SIZE  ALU opcode
- o_tx_start  out  1  start request to the UART TX; held until i_tx_active
- o_tx_data  out  DATA_SIZE  byte to transmit; stable from o_tx_start rise until i_tx_done
- i_tx_active  in  1  UART TX is shifting
- i_tx_done  in  1  UART TX finished the byte
- i_rx_done  in  1  UART RX byte available; may stay high for more than one cycle
- i_rx_data  in  DATA_SIZE  received byte
- o_resp_valid  out  1  result available
- i_resp_ready  in  1  consumer accepts the result
- o_resp_data  out  DATA_SIZE  ALU result
- o_timeout  out  1  one-cycle pulse when a request is aborted
- o_busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: waits for a request.
  - START: raises o_tx_start.
  - WAIT_DONE: waits for the TX to finish the byte.
  - WAIT_RX: waits for the result byte.
  - RESP: presents the result.
- IDLE: o_req_ready=1. On i_req_valid, latch A, B and {0, opcode}, clear byte index idx to 0, and go to START.
- START: o_tx_start=1 and o_tx_data=byte[idx], where byte[0]=A, byte[1]=B, byte[2]=opcode. On i_tx_active, drop o_tx_start in the next cycle and go to WAIT_DONE.
- WAIT_DONE: on i_tx_done, if idx==2 clear the timeout counter and go to WAIT_RX; otherwise increment idx and go to START.
- WAIT_RX: the counter increments every cycle.
  - On a rising edge of i_rx_done (i_rx_done & ~rx_done_q, where rx_done_q is a registered copy updated every cycle in all states), capture i_rx_data into o_resp_data and go to RESP.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no edge, pulse o_timeout for one cycle and go to IDLE. o_resp_data is unchanged.
- RESP: o_resp_valid=1 until i_resp_ready is sampled high, then go to IDLE.
- i_rx_done edges outside WAIT_RX are ignored. A stale level of i_rx_done entering WAIT_RX does not count as an edge.
- i_req_* and i_tx_done are ignored outside their states. i_tx_done in START is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) gives:
  - state=IDLE, idx=0, counter=0, rx_done_q=0
  - o_tx_start=0, o_tx_data=0, o_resp_valid=0, o_resp_data=0, o_timeout=0, o_busy=0
  - o_req_ready=1
- All outputs are registered or decoded from the state only. There is no combinational path from inputs to outputs.
- Request acceptance to o_tx_start high: 1 cycle.
- i_tx_active to o_tx_start low: 1 cycle.
- i_tx_done on the last byte to WAIT_RX: 1 cycle.
- i_rx_done rise to o_resp_valid: 1 cycle.
- The cycle after a response handshake, o_req_ready=1. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Simultaneous events:
  - If the rx edge and timeout terminal count occur in the same cycle, the rx edge wins and there is no o_timeout.
  - If i_tx_active and i_tx_done are both high in START, only i_tx_active is honoured.
- Reset mid-transfer aborts immediately. o_tx_start drops asynchronously and no response is produced.

## Test plan
- Basic ADD: req A=8'h05, B=8'h03, opcode=6'h20. Respond to each o_tx_start with active 2 cycles later and done 10 cycles later -> o_tx_data sequence 05, 03, 20. Then the RX model returns 8'h08 -> o_resp_valid with o_resp_data=8'h08, o_busy low after the handshake.
- Held rx_done: i_rx_done held high 5 cycles with data 8'hAA, and resp_ready held low 3 cycles -> exactly one response 8'hAA, valid stays high until ready, no second capture.
- Timeout: TIMEOUT_CYCLES=16, no RX -> o_timeout pulses exactly 16 cycles after entering WAIT_RX, state returns to IDLE, o_resp_valid never asserted.
- Race: rx edge on the terminal timeout cycle -> response captured, o_timeout stays 0.
- Reset mid-operation: assert i_reset_n low while o_tx_start is high for byte B -> all outputs at reset values within the same cycle. The next request sends A first.
- Spurious inputs: toggle i_rx_done and i_tx_done during IDLE and START -> no state change, no o_tx_start glitch, o_tx_data unchanged.

Source files
------------

// File: rtl/alu_uart_requester.sv
`default_nettype none
// ============================================================================
// Module   : alu_uart_requester
// Purpose  : Host-side initiator for the UART ALU link. It accepts one
//            A/B/opcode request and sends A, B and the zero-extended opcode
//            through the local UART transmitter. It then waits for the
//            single result byte from the local UART receiver and returns it
//            on a valid/ready response port. The wait for the result can
//            time out.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_SIZE      width of operands, result and UART bytes
//   OPCODE_SIZE    opcode width; sent zero-extended to DATA_SIZE
//   TIMEOUT_CYCLES maximum cycles spent waiting for the result (0 = never)
//   CNT_W          timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES
// Ports
//   i_clk, i_reset_n             clock, asynchronous active-low reset
//   i_req_valid / o_req_ready    request handshake (ready only when idle)
//   i_req_a, i_req_b             operands A and B
//   i_req_opcode                 ALU opcode
//   o_tx_start, o_tx_data        UART TX start request and byte
//   i_tx_active, i_tx_done       UART TX shifting / byte finished
//   i_rx_done, i_rx_data         UART RX byte available / received byte
//   o_resp_valid / i_resp_ready  response handshake
//   o_resp_data                  ALU result
//   o_timeout                    one-cycle pulse when a request is aborted
//   o_busy                       high whenever not idle
// ============================================================================
module alu_uart_requester #(
  parameter int DATA_SIZE      = 8,
  parameter int OPCODE_SIZE    = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [DATA_SIZE-1:0]   i_req_a,
  input  logic [DATA_SIZE-1:0]   i_req_b,
  input  logic [OPCODE_SIZE-1:0] i_req_opcode,
  output logic                   o_tx_start,
  output logic [DATA_SIZE-1:0]   o_tx_data,
  input  logic                   i_tx_active,
  input  logic                   i_tx_done,
  input  logic                   i_rx_done,
  input  logic [DATA_SIZE-1:0]   i_rx_data,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [DATA_SIZE-1:0]   o_resp_data,
  output logic                   o_timeout,
  output logic                   o_busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_WAIT_RX   = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  // Counter value on the last permitted waiting cycle. When the timeout is
  // disabled the value is irrelevant because the compare is gated off.
  localparam logic [CNT_W-1:0] TERM_CNT =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAST_IDX = 2'd2;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rx_done_q;
  logic [DATA_SIZE-1:0] b_q, b_d;
  logic [DATA_SIZE-1:0] op_q, op_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic [DATA_SIZE-1:0] resp_data_q, resp_data_d;
  logic                 timeout_q, timeout_d;

  logic                 w_rx_edge;
  logic                 w_cnt_term;

  // Only a fresh rise of i_rx_done counts; a level that was already high when
  // WAIT_RX is entered is ignored because rx_done_q tracks it in every state.
  assign w_rx_edge  = i_rx_done & ~rx_done_q;
  assign w_cnt_term = (TIMEOUT_CYCLES != 0) && (cnt_q == TERM_CNT);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    op_d        = op_q;
    tx_data_d   = tx_data_q;
    resp_data_d = resp_data_q;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          // Byte A goes straight into the TX data register so it is already
          // stable on the cycle o_tx_start rises; B and the opcode wait.
          tx_data_d = i_req_a;
          b_d       = i_req_b;
          op_d      = DATA_SIZE'(i_req_opcode);
          idx_d     = 2'd0;
          state_d   = S_START;
        end
      end

      S_START: begin
        // i_tx_done is deliberately not looked at here, even when it arrives
        // together with i_tx_active.
        if (i_tx_active) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_WAIT_RX;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = (idx_q == 2'd0) ? b_q : op_q;
            state_d   = S_START;
          end
        end
      end

      S_WAIT_RX: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the terminal cycle beats the timeout.
        if (w_rx_edge) begin
          resp_data_d = i_rx_data;
          state_d     = S_RESP;
        end else if (w_cnt_term) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_RESP: begin
        if (i_resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      rx_done_q   <= 1'b0;
      b_q         <= '0;
      op_q        <= '0;
      tx_data_q   <= '0;
      resp_data_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rx_done_q   <= i_rx_done;
      b_q         <= b_d;
      op_q        <= op_d;
      tx_data_q   <= tx_data_d;
      resp_data_q <= resp_data_d;
      timeout_q   <= timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or pure state decodes, no input-to-output paths.
  // The state register resets asynchronously, so o_tx_start drops at once.
  // --------------------------------------------------------------------------
  assign o_req_ready  = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_tx_start   = (state_q == S_START);
  assign o_resp_valid = (state_q == S_RESP);
  assign o_tx_data    = tx_data_q;
  assign o_resp_data  = resp_data_q;
  assign o_timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_uart_requester
// Purpose  : Self-checking bench for alu_uart_requester. It uses a table of
//            directed transactions, hand-written reset and spurious-input
//            sequences, and randomized transactions. Expected bytes and
//            outcomes come from a small behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_uart_requester;

  localparam int DW  = 8;
  localparam int OW  = 6;
  localparam int TMO = 16;
  localparam int CW  = 5;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [DW-1:0] i_req_a = '0;
  logic [DW-1:0] i_req_b = '0;
  logic [OW-1:0] i_req_opcode = '0;
  logic          o_tx_start;
  logic [DW-1:0] o_tx_data;
  logic          i_tx_active = 1'b0;
  logic          i_tx_done = 1'b0;
  logic          i_rx_done = 1'b0;
  logic [DW-1:0] i_rx_data = '0;
  logic          o_resp_valid;
  logic          i_resp_ready = 1'b0;
  logic [DW-1:0] o_resp_data;
  logic          o_timeout;
  logic          o_busy;

  alu_uart_requester #(
    .DATA_SIZE(DW), .OPCODE_SIZE(OW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_opcode(i_req_opcode),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_data(o_resp_data), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    int         act_dly;   // cycles o_tx_start is left waiting for active
    int         done_dly;  // cycles between active and done
    int         rx_dly;    // WAIT_RX cycle on which rx_done rises (>=TMO: never)
    logic [7:0] rx_data;
    int         rx_hold;   // cycles rx_done stays high
    int         ready_dly; // cycles resp_ready stays low
    bit         noisy;     // toggle tx_done/rx_done during START
    bit         exp_tmo;
    logic [7:0] exp_data;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         rx_left = 0;
  logic [7:0] last_resp = '0;

  // Behavioural model: the request times out unless the result rises within
  // the first TMO cycles of waiting; the result byte is whatever RX delivers.
  function automatic bit model_timeout(input int rx_dly);
    return !(rx_dly >= 0 && rx_dly < TMO);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (rx_left > 0) begin
      rx_left--;
      if (rx_left == 0) i_rx_done = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] exp_bytes [3];
    bit saw_tmo;
    bit saw_resp;
    int evt_cycle;
    exp_bytes[0] = v.a;
    exp_bytes[1] = v.b;
    exp_bytes[2] = {2'b00, v.op};
    saw_tmo  = 1'b0;
    saw_resp = 1'b0;
    evt_cycle = -1;

    check("req_ready_idle", o_req_ready, 1);
    i_req_valid  = 1'b1;
    i_req_a      = v.a;
    i_req_b      = v.b;
    i_req_opcode = v.op;
    tick();
    // Scramble request inputs: the DUT must use its latched copy.
    i_req_valid  = 1'b0;
    i_req_a      = 8'($urandom);
    i_req_b      = 8'($urandom);
    i_req_opcode = 6'($urandom);
    check("busy_after_accept", o_busy, 1);

    for (int k = 0; k < 3; k++) begin
      check("tx_start_rise", o_tx_start, 1);
      check("tx_data_byte", o_tx_data, exp_bytes[k]);
      for (int d = 0; d < v.act_dly; d++) begin
        if (v.noisy) begin
          i_tx_done = d[0];
          i_rx_done = ~d[0];
        end
        tick();
        check("tx_start_hold", o_tx_start, 1);
        check("tx_data_hold_start", o_tx_data, exp_bytes[k]);
      end
      if (v.noisy) i_rx_done = 1'b0;
      i_tx_active = 1'b1;
      i_tx_done   = v.noisy;  // simultaneous done must be ignored
      tick();
      i_tx_done = 1'b0;
      check("tx_start_drop", o_tx_start, 0);
      for (int d = 0; d < v.done_dly; d++) begin
        tick();
        check("tx_start_low_wait_done", o_tx_start, 0);
        check("tx_data_hold_done", o_tx_data, exp_bytes[k]);
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done   = 1'b0;
      i_tx_active = 1'b0;
    end

    check("tx_start_low_wait_rx", o_tx_start, 0);
    check("busy_wait_rx", o_busy, 1);

    for (int c = 0; c <= TMO && !saw_tmo && !saw_resp; c++) begin
      if (c == v.rx_dly) begin
        i_rx_done = 1'b1;
        i_rx_data = v.rx_data;
        rx_left   = v.rx_hold;
      end
      tick();
      if (o_timeout)    begin saw_tmo  = 1'b1; evt_cycle = c + 1; end
      if (o_resp_valid) begin saw_resp = 1'b1; evt_cycle = c + 1; end
    end
    check("outcome_timeout", saw_tmo, v.exp_tmo);
    check("outcome_resp", saw_resp, !v.exp_tmo);

    if (saw_tmo) begin
      check("timeout_latency", evt_cycle, TMO);
      check("resp_data_kept", o_resp_data, last_resp);
      check("resp_valid_on_tmo", o_resp_valid, 0);
      check("req_ready_after_tmo", o_req_ready, 1);
      tick();
      check("timeout_one_cycle", o_timeout, 0);
      check("resp_valid_after_tmo", o_resp_valid, 0);
    end
    if (saw_resp) begin
      check("resp_latency", evt_cycle, v.rx_dly + 1);
      check("resp_data", o_resp_data, v.exp_data);
      check("timeout_with_resp", o_timeout, 0);
      for (int r = 0; r < v.ready_dly; r++) begin
        tick();
        check("resp_valid_hold", o_resp_valid, 1);
        check("resp_data_hold", o_resp_data, v.exp_data);
      end
      i_resp_ready = 1'b1;
      tick();
      i_resp_ready = 1'b0;
      check("resp_valid_after_hs", o_resp_valid, 0);
      check("req_ready_after_hs", o_req_ready, 1);
      check("busy_after_hs", o_busy, 0);
      last_resp = v.exp_data;
      tick();
      check("no_second_capture", o_resp_valid, 0);
    end
    i_rx_done = 1'b0;
    rx_left   = 0;
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    //            a      b      op     act dn rx  rxd    hld rdy noisy tmo exp
    tbl[0] = '{8'h05, 8'h03, 6'h20, 2, 8, 3,  8'h08, 1, 0, 1'b0, 1'b0, 8'h08};
    tbl[1] = '{8'hA1, 8'hB2, 6'h07, 1, 3, 2,  8'hAA, 5, 3, 1'b0, 1'b0, 8'hAA};
    tbl[2] = '{8'h11, 8'h22, 6'h3F, 0, 0, 99, 8'h00, 1, 0, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{8'h7E, 8'h81, 6'h15, 1, 2, 15, 8'h5C, 1, 1, 1'b0, 1'b0, 8'h5C};
    tbl[4] = '{8'hFF, 8'h00, 6'h3F, 0, 0, 0,  8'hFF, 2, 0, 1'b0, 1'b0, 8'hFF};
    tbl[5] = '{8'h3C, 8'hC3, 6'h2A, 4, 1, 5,  8'h66, 1, 2, 1'b1, 1'b0, 8'h66};
    tbl[6] = '{8'h01, 8'h02, 6'h01, 1, 1, 14, 8'h03, 3, 0, 1'b0, 1'b0, 8'h03};

    // Reset state
    #1;
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_resp_valid", o_resp_valid, 0);
    check("rst_resp_data", o_resp_data, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_busy", o_busy, 0);
    check("rst_req_ready", o_req_ready, 1);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();

    // Spurious rx_done / tx_done while idle
    for (int i = 0; i < 6; i++) begin
      i_rx_done = i[0];
      i_tx_done = ~i[0];
      tick();
      check("idle_spur_ready", o_req_ready, 1);
      check("idle_spur_busy", o_busy, 0);
      check("idle_spur_start", o_tx_start, 0);
      check("idle_spur_data", o_tx_data, 0);
      check("idle_spur_valid", o_resp_valid, 0);
    end
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Reset while o_tx_start is high for byte B
    i_req_valid  = 1'b1;
    i_req_a      = 8'hC3;
    i_req_b      = 8'h3C;
    i_req_opcode = 6'h01;
    tick();
    i_req_valid = 1'b0;
    i_tx_active = 1'b1;
    tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done   = 1'b0;
    i_tx_active = 1'b0;
    check("midrst_start_b", o_tx_start, 1);
    check("midrst_data_b", o_tx_data, 8'h3C);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("midrst_tx_start", o_tx_start, 0);
    check("midrst_tx_data", o_tx_data, 0);
    check("midrst_resp_valid", o_resp_valid, 0);
    check("midrst_resp_data", o_resp_data, 0);
    check("midrst_timeout", o_timeout, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", o_req_ready, 1);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    last_resp = 8'h00;
    tick();
    run_txn(tbl[0]);

    // Randomized transactions against the model
    for (int i = 0; i < 24; i++) begin
      rv.a         = 8'($urandom);
      rv.b         = 8'($urandom);
      rv.op        = 6'($urandom);
      rv.act_dly   = int'($urandom_range(0, 3));
      rv.done_dly  = int'($urandom_range(0, 4));
      rv.rx_dly    = int'($urandom_range(0, 19));
      rv.rx_data   = 8'($urandom);
      rv.rx_hold   = int'($urandom_range(1, 4));
      rv.ready_dly = int'($urandom_range(0, 3));
      rv.noisy     = 1'($urandom);
      rv.exp_tmo   = model_timeout(rv.rx_dly);
      rv.exp_data  = rv.rx_data;
      run_txn(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
